// File: rtl/vga_timing_gen.sv
// Programmable raster timing generator: pixel divider, column/row counters,
// sync and active-video decode, and a linear frame-buffer read address.
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CNT_W    = 10,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              enable,
  output logic              pixel_clk,
  output logic              pixel_stb,
  output logic [CNT_W-1:0]  col,
  output logic [CNT_W-1:0]  row,
  output logic              hsync,
  output logic              vsync,
  output logic              active,
  output logic [ADDR_W-1:0] addr,
  output logic              line_start,
  output logic              frame_start
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int PH_W     = $clog2(CLK_DIV);

  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]   PH_HALF   = PH_W'(CLK_DIV / 2);
  localparam logic [CNT_W-1:0]  COL_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0]  ROW_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0]  H_ACT_C   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0]  V_ACT_C   = CNT_W'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  // Reject degenerate timings at elaboration.
  if (CLK_DIV < 2 || H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
      (H_TOTAL - 1) >= (2 ** CNT_W) || (V_TOTAL - 1) >= (2 ** CNT_W) ||
      (H_ACTIVE * V_ACTIVE - 1) >= (2 ** ADDR_W)) begin : g_param_check
    $error("vga_timing_gen: invalid timing or width parameters");
  end

  // True when v lies in [lo, lo+len-1].
  function automatic logic in_window(input logic [CNT_W-1:0] v, input int lo, input int len);
    return (int'(v) >= lo) && (int'(v) < lo + len);
  endfunction

  // Address increment that parks on the last visible pixel instead of running past it.
  function automatic logic [ADDR_W-1:0] addr_sat_inc(input logic [ADDR_W-1:0] a);
    return (a == ADDR_LAST) ? a : a + ADDR_W'(1);
  endfunction

  logic [PH_W-1:0]   phase_q, phase_d;
  logic [CNT_W-1:0]  col_q, col_d;
  logic [CNT_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              hsync_q, hsync_d;
  logic              vsync_q, vsync_d;
  logic              active_q, active_d;
  logic              col_last, row_last;

  assign pixel_stb   = enable && (phase_q == PH_LAST);
  assign pixel_clk   = (phase_q < PH_HALF);
  assign col_last    = (col_q == COL_LAST);
  assign row_last    = (row_q == ROW_LAST);
  assign line_start  = pixel_stb && col_last;
  assign frame_start = line_start && row_last;

  // Divider phase: counts while enabled, holds otherwise.
  always_comb begin
    phase_d = phase_q;
    if (enable) begin
      phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
    end
  end

  // Raster advance on each pixel strobe; sync/active decoded from the next position
  // so the registered versions line up with the registered col/row.
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    addr_d = addr_q;
    if (pixel_stb) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + CNT_W'(1);
      end else begin
        col_d = col_q + CNT_W'(1);
      end
      if (frame_start) begin
        addr_d = '0;
      end else if (active_q) begin
        addr_d = addr_sat_inc(addr_q);
      end
    end
    hsync_d  = in_window(col_d, HS_START, H_SYNC) ? HS_POL : ~HS_POL;
    vsync_d  = in_window(row_d, VS_START, V_SYNC) ? VS_POL : ~VS_POL;
    active_d = (col_d < H_ACT_C) && (row_d < V_ACT_C);
  end

  // State registers with asynchronous return to the top-left, sync-idle state.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      phase_q  <= '0;
      col_q    <= '0;
      row_q    <= '0;
      addr_q   <= '0;
      hsync_q  <= ~HS_POL;
      vsync_q  <= ~VS_POL;
      active_q <= 1'b1;
    end else begin
      phase_q  <= phase_d;
      col_q    <= col_d;
      row_q    <= row_d;
      addr_q   <= addr_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      active_q <= active_d;
    end
  end

  assign col    = col_q;
  assign row    = row_q;
  assign addr   = addr_q;
  assign hsync  = hsync_q;
  assign vsync  = vsync_q;
  assign active = active_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised-enable bench for vga_timing_gen with three configurations
// (defaults, a medium raster and a tiny raster) against a pixel-count model.
module tb_vga_timing_gen;

  typedef struct packed {
    int col; int row; int addr;
    bit pclk; bit stb; bit hs; bit vs; bit act; bit ls; bit fs;
  } obs_t;

  typedef struct packed {
    int cd; int ha; int hf; int hs; int hb; int va; int vf; int vs; int vb; int hp; int vp;
  } cfg_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] en_v = 3'b000;
  logic [2:0] nr_v = 3'b111;
  int   sel = 0;

  logic        d0_pclk, d0_stb, d0_hs, d0_vs, d0_act, d0_ls, d0_fs;
  logic [9:0]  d0_col, d0_row;
  logic [18:0] d0_addr;
  logic        d1_pclk, d1_stb, d1_hs, d1_vs, d1_act, d1_ls, d1_fs;
  logic [4:0]  d1_col, d1_row;
  logic [6:0]  d1_addr;
  logic        d2_pclk, d2_stb, d2_hs, d2_vs, d2_act, d2_ls, d2_fs;
  logic [2:0]  d2_col, d2_row;
  logic [2:0]  d2_addr;

  vga_timing_gen u_def (
    .clk(clk), .n_rst(nr_v[0]), .enable(en_v[0]), .pixel_clk(d0_pclk), .pixel_stb(d0_stb),
    .col(d0_col), .row(d0_row), .hsync(d0_hs), .vsync(d0_vs), .active(d0_act),
    .addr(d0_addr), .line_start(d0_ls), .frame_start(d0_fs));

  vga_timing_gen #(
    .CLK_DIV(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(5), .ADDR_W(7)
  ) u_med (
    .clk(clk), .n_rst(nr_v[1]), .enable(en_v[1]), .pixel_clk(d1_pclk), .pixel_stb(d1_stb),
    .col(d1_col), .row(d1_row), .hsync(d1_hs), .vsync(d1_vs), .active(d1_act),
    .addr(d1_addr), .line_start(d1_ls), .frame_start(d1_fs));

  vga_timing_gen #(
    .CLK_DIV(3), .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(3), .ADDR_W(3)
  ) u_small (
    .clk(clk), .n_rst(nr_v[2]), .enable(en_v[2]), .pixel_clk(d2_pclk), .pixel_stb(d2_stb),
    .col(d2_col), .row(d2_row), .hsync(d2_hs), .vsync(d2_vs), .active(d2_act),
    .addr(d2_addr), .line_start(d2_ls), .frame_start(d2_fs));

  obs_t obs;
  always_comb begin
    obs = '0;
    case (sel)
      0: begin
        obs.col = int'(d0_col); obs.row = int'(d0_row); obs.addr = int'(d0_addr);
        obs.pclk = d0_pclk; obs.stb = d0_stb; obs.hs = d0_hs; obs.vs = d0_vs;
        obs.act = d0_act; obs.ls = d0_ls; obs.fs = d0_fs;
      end
      1: begin
        obs.col = int'(d1_col); obs.row = int'(d1_row); obs.addr = int'(d1_addr);
        obs.pclk = d1_pclk; obs.stb = d1_stb; obs.hs = d1_hs; obs.vs = d1_vs;
        obs.act = d1_act; obs.ls = d1_ls; obs.fs = d1_fs;
      end
      default: begin
        obs.col = int'(d2_col); obs.row = int'(d2_row); obs.addr = int'(d2_addr);
        obs.pclk = d2_pclk; obs.stb = d2_stb; obs.hs = d2_hs; obs.vs = d2_vs;
        obs.act = d2_act; obs.ls = d2_ls; obs.fs = d2_fs;
      end
    endcase
  end

  cfg_t cfgs [3];
  obs_t exp_q [$];
  int   checks = 0;
  int   errors = 0;
  int   E = 0;           // enabled clocks since reset release
  bit   nr_want = 1'b0;
  int   cyc = 0, vis_cnt = 0, prev_fs = -1, last_period = -1, last_vis = -1;

  // Reference: position follows directly from the number of enabled clocks.
  function automatic obs_t model(input int e, input bit en, input cfg_t c);
    obs_t o;
    int ht, vt, ph, n, a;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    ph = e % c.cd;
    n  = e / c.cd;
    o = '0;
    o.col  = n % ht;
    o.row  = (n / ht) % vt;
    o.pclk = (ph < c.cd / 2);
    o.stb  = en && (ph == c.cd - 1);
    o.hs   = (o.col >= c.ha + c.hf && o.col < c.ha + c.hf + c.hs) ? c.hp[0] : !c.hp[0];
    o.vs   = (o.row >= c.va + c.vf && o.row < c.va + c.vf + c.vs) ? c.vp[0] : !c.vp[0];
    o.act  = (o.col < c.ha) && (o.row < c.va);
    if (o.row < c.va) a = o.row * c.ha + ((o.col < c.ha) ? o.col : c.ha);
    else              a = c.ha * c.va;
    if (a > c.ha * c.va - 1) a = c.ha * c.va - 1;
    o.addr = a;
    o.ls   = o.stb && (o.col == ht - 1);
    o.fs   = o.ls && (o.row == vt - 1);
    return o;
  endfunction

  task automatic check(input string nm, input obs_t g, input obs_t x);
    checks++;
    if (g !== x) begin
      errors++;
      $display("FAIL %s dut=%0d t=%0t got col=%0d row=%0d addr=%0d pclk=%0b stb=%0b hs=%0b vs=%0b act=%0b ls=%0b fs=%0b | exp col=%0d row=%0d addr=%0d pclk=%0b stb=%0b hs=%0b vs=%0b act=%0b ls=%0b fs=%0b",
               nm, sel, $time, g.col, g.row, g.addr, g.pclk, g.stb, g.hs, g.vs, g.act, g.ls, g.fs,
               x.col, x.row, x.addr, x.pclk, x.stb, x.hs, x.vs, x.act, x.ls, x.fs);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s dut=%0d got=%0d exp=%0d", nm, sel, got, want);
    end
  endtask

  function automatic bit rnd_en();
    return ($urandom_range(0, 3) != 0);
  endfunction

  // One clock of stimulus: drive, queue the expected view, advance the model.
  task automatic step(input bit en);
    @(negedge clk);
    en_v[sel] = en;
    nr_v[sel] = nr_want;
    #1;
    exp_q.push_back(model(E, en, cfgs[sel]));
    if (en && nr_want) E++;
  endtask

  // Asynchronous reset asserted between clock edges, checked before the next edge.
  task automatic pulse_reset();
    #2;
    nr_v[sel] = 1'b0;
    nr_want = 1'b0;
    #1;
    check("async_reset", obs, model(0, en_v[sel], cfgs[sel]));
    E = 0;
    step(1'b1);
    step(1'b1);
    nr_want = 1'b1;
  endtask

  // Monitor: pops one expectation per clock and keeps frame statistics.
  initial begin
    obs_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cycle", obs, e);
        cyc++;
        if (obs.stb && obs.act) vis_cnt++;
        if (obs.fs) begin
          last_vis = vis_cnt;
          vis_cnt = 0;
          if (prev_fs >= 0) last_period = cyc - prev_fs;
          prev_fs = cyc;
        end
      end
    end
  end

  task automatic run_section(input int k);
    int per;
    sel = k; E = 0; nr_want = 1'b0;
    cyc = 0; vis_cnt = 0; prev_fs = -1; last_period = -1; last_vis = -1;
    nr_v[k] = 1'b0;
    en_v[k] = 1'b0;
    #1;
    check("reset_values", obs, model(0, 1'b0, cfgs[k]));
    nr_want = 1'b1;
    per = cfgs[k].cd * (cfgs[k].ha + cfgs[k].hf + cfgs[k].hs + cfgs[k].hb) *
          (cfgs[k].va + cfgs[k].vf + cfgs[k].vs + cfgs[k].vb);
    if (k == 0) begin
      while (E < 601) step(1'b1);          // col 300, phase 1
      repeat (7) step(1'b0);
      repeat (40) step(1'b1);
      repeat (1500) step(rnd_en());
      while (E < 4200) step(1'b1);         // row 2, col 500
      pulse_reset();
      repeat (1500) step(rnd_en());
    end else begin
      repeat (2 * per + 2) step(1'b1);
      #2;
      check_int("frame_period", last_period, per);
      check_int("visible_pixels", last_vis, cfgs[k].ha * cfgs[k].va);
      repeat (3 * per) step(rnd_en());
      pulse_reset();
      repeat (2 * per) step(rnd_en());
    end
    #2;
    en_v[k] = 1'b0;
  endtask

  initial begin
    cfgs[0] = '{cd:2, ha:640, hf:16, hs:96, hb:48, va:480, vf:10, vs:2, vb:33, hp:0, vp:0};
    cfgs[1] = '{cd:2, ha:16,  hf:2,  hs:3,  hb:2,  va:6,   vf:1,  vs:2, vb:1,  hp:0, vp:0};
    cfgs[2] = '{cd:3, ha:4,   hf:1,  hs:1,  hb:1,  va:2,   vf:1,  vs:1, vb:1,  hp:1, vp:1};
    en_v = 3'b000;
    nr_v = 3'b000;
    for (int k = 0; k < 3; k++) run_section(k);
    check_int("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
